// File: rtl/caminho_pkg.sv
// Shared types and default sizes for the path extractor that follows the path-search core.
package caminho_pkg;

   localparam int CAMINHO_ADDR_WIDTH   = 10;
   localparam int CAMINHO_MAX_PATH_LEN = 64;

   typedef logic [CAMINHO_ADDR_WIDTH-1:0] no_addr_t;

   typedef enum logic [2:0] {
      IDLE,
      PUSH_DST,
      LER,
      ESPERA,
      STREAM,
      FIM,
      ERRO
   } caminho_estado_t;

endpackage

// File: rtl/caminho_pilha.sv
// Parameterised LIFO holding the nodes of the path while it is walked backwards.
module caminho_pilha
   import caminho_pkg::*;
#(
   parameter int  DEPTH = CAMINHO_MAX_PATH_LEN,
   parameter int  WIDTH = CAMINHO_ADDR_WIDTH,
   localparam int PTR_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] top_out,
   output logic [PTR_W-1:0] count_out,
   output logic             full_out,
   output logic             empty_out
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] count;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;

   assign wr_idx    = IDX_W'(count);
   assign top_idx   = IDX_W'(count - PTR_W'(1));
   assign full_out  = (count == PTR_W'(DEPTH));
   assign empty_out = (count == '0);
   assign top_out   = empty_out ? '0 : mem[top_idx];
   assign count_out = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (push && !full_out) begin
         count <= count + PTR_W'(1);
      end else if (pop && !empty_out) begin
         count <= count - PTR_W'(1);
      end
   end

   // NOTE: storage is deliberately not reset; count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push && !full_out) begin
         mem[wr_idx] <= data_in;
      end
   end

   ap_no_push_pop: assert property (@(posedge clk) disable iff (rst) !(push && pop));
   ap_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full_out));

endmodule

// File: rtl/caminho_extrator.sv
// Walks the predecessor memory from destino back to fonte and streams the path forward.
// Optional CAMINHO_COMPRIMENTO_EN adds ext_comprimento_out (node count of the last path).
module caminho_extrator
   import caminho_pkg::*;
#(
   parameter int  ADDR_WIDTH   = CAMINHO_ADDR_WIDTH,
   parameter int  MAX_PATH_LEN = CAMINHO_MAX_PATH_LEN,
   localparam int PTR_WIDTH    = $clog2(MAX_PATH_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ext_start_in,
   input  logic [ADDR_WIDTH-1:0] ext_fonte_in,
   input  logic [ADDR_WIDTH-1:0] ext_destino_in,
   output logic                  ext_ant_rd_out,
   output logic [ADDR_WIDTH-1:0] ext_ant_addr_out,
   input  logic [ADDR_WIDTH-1:0] ext_ant_data_in,
   output logic                  ext_path_valid_out,
   output logic [ADDR_WIDTH-1:0] ext_path_data_out,
   output logic                  ext_path_last_out,
   input  logic                  ext_path_ready_in,
   output logic                  ext_busy_out,
   output logic                  ext_done_out,
   output logic                  ext_erro_out
`ifdef CAMINHO_COMPRIMENTO_EN
   ,
   output logic [PTR_WIDTH-1:0]  ext_comprimento_out
`endif
);

   caminho_estado_t       estado;
   logic [ADDR_WIDTH-1:0] fonte_q;
   logic [ADDR_WIDTH-1:0] destino_q;
   logic [ADDR_WIDTH-1:0] cur_q;

   logic                  pilha_push;
   logic                  pilha_pop;
   logic                  pilha_flush;
   logic [ADDR_WIDTH-1:0] pilha_din;
   logic [ADDR_WIDTH-1:0] pilha_top;
   logic [PTR_WIDTH-1:0]  pilha_count;
   logic                  pilha_full;
   logic                  pilha_empty;

   logic                  hop_self;
   logic                  ultimo;

   assign hop_self = (ext_ant_data_in == cur_q);
   assign ultimo   = (pilha_count == PTR_WIDTH'(1));

   // Stream outputs derive only from registers, so ready never reaches an output.
   assign ext_path_data_out = ext_path_valid_out ? pilha_top : '0;
   assign ext_path_last_out = ext_path_valid_out && ultimo;

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      pilha_push  = 1'b0;
      pilha_pop   = 1'b0;
      pilha_flush = 1'b0;
      pilha_din   = ext_ant_data_in;
      unique case (estado)
         PUSH_DST: begin
            pilha_push = 1'b1;
            pilha_din  = destino_q;
         end
         ESPERA:  pilha_push  = !hop_self && !pilha_full;
         STREAM:  pilha_pop   = ext_path_valid_out && ext_path_ready_in && !pilha_empty;
         ERRO:    pilha_flush = 1'b1;
         default: ;
      endcase
   end

   caminho_pilha #(
      .DEPTH (MAX_PATH_LEN),
      .WIDTH (ADDR_WIDTH)
   ) u_pilha (
      .clk       (clk),
      .rst       (rst),
      .push      (pilha_push),
      .pop       (pilha_pop),
      .flush     (pilha_flush),
      .data_in   (pilha_din),
      .top_out   (pilha_top),
      .count_out (pilha_count),
      .full_out  (pilha_full),
      .empty_out (pilha_empty)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado             <= IDLE;
         fonte_q            <= '0;
         destino_q          <= '0;
         cur_q              <= '0;
         ext_ant_rd_out     <= 1'b0;
         ext_ant_addr_out   <= '0;
         ext_path_valid_out <= 1'b0;
         ext_busy_out       <= 1'b0;
         ext_done_out       <= 1'b0;
         ext_erro_out       <= 1'b0;
`ifdef CAMINHO_COMPRIMENTO_EN
         ext_comprimento_out <= '0;
`endif
      end else begin
         ext_ant_rd_out <= 1'b0;
         ext_done_out   <= 1'b0;
         ext_erro_out   <= 1'b0;
         unique case (estado)
            IDLE: begin
               if (ext_start_in) begin
                  fonte_q      <= ext_fonte_in;
                  destino_q    <= ext_destino_in;
                  cur_q        <= ext_destino_in;
                  ext_busy_out <= 1'b1;
                  estado       <= PUSH_DST;
`ifdef CAMINHO_COMPRIMENTO_EN
                  ext_comprimento_out <= '0;
`endif
               end
            end
            PUSH_DST: begin
               if (destino_q == fonte_q) begin
                  ext_path_valid_out <= 1'b1;
                  estado             <= STREAM;
`ifdef CAMINHO_COMPRIMENTO_EN
                  ext_comprimento_out <= PTR_WIDTH'(1);
`endif
               end else begin
                  ext_ant_rd_out   <= 1'b1;
                  ext_ant_addr_out <= cur_q;
                  estado           <= LER;
               end
            end
            LER: estado <= ESPERA;
            ESPERA: begin
               // A self-predecessor marks an unreached node; it is tested before capacity.
               if (hop_self || pilha_full) begin
                  ext_erro_out <= 1'b1;
                  estado       <= ERRO;
               end else begin
                  cur_q <= ext_ant_data_in;
                  if (ext_ant_data_in == fonte_q) begin
                     ext_path_valid_out <= 1'b1;
                     estado             <= STREAM;
`ifdef CAMINHO_COMPRIMENTO_EN
                     ext_comprimento_out <= pilha_count + PTR_WIDTH'(1);
`endif
                  end else begin
                     ext_ant_rd_out   <= 1'b1;
                     ext_ant_addr_out <= ext_ant_data_in;
                     estado           <= LER;
                  end
               end
            end
            STREAM: begin
               if (pilha_pop && ultimo) begin
                  ext_path_valid_out <= 1'b0;
                  ext_done_out       <= 1'b1;
                  estado             <= FIM;
               end
            end
            FIM: begin
               ext_busy_out <= 1'b0;
               estado       <= IDLE;
            end
            ERRO: begin
               ext_busy_out <= 1'b0;
               estado       <= IDLE;
`ifdef CAMINHO_COMPRIMENTO_EN
               ext_comprimento_out <= '0;
`endif
            end
            default: begin
               ext_path_valid_out <= 1'b0;
               ext_busy_out       <= 1'b0;
               estado             <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_caminho_extrator.sv
// Scoreboard bench for caminho_extrator: a path-walk reference model fills expectation queues,
// a negedge monitor pops and compares beats, reads and done/erro pulses.
module tb_caminho_extrator;
   import caminho_pkg::*;

   localparam int AW   = CAMINHO_ADDR_WIDTH;
   localparam int MAXP = 4;
   localparam int PW   = $clog2(MAXP + 1);

   typedef struct packed {
      no_addr_t data;
      logic     last;
   } beat_t;

   typedef enum logic {EV_DONE, EV_ERRO} ev_t;

   logic     clk = 1'b0;
   logic     rst = 1'b0;
   logic     ext_start_in = 1'b0;
   no_addr_t ext_fonte_in = '0;
   no_addr_t ext_destino_in = '0;
   logic     ext_ant_rd_out;
   no_addr_t ext_ant_addr_out;
   no_addr_t ext_ant_data_in = '0;
   logic     ext_path_valid_out;
   no_addr_t ext_path_data_out;
   logic     ext_path_last_out;
   logic     ext_path_ready_in = 1'b1;
   logic     ext_busy_out;
   logic     ext_done_out;
   logic     ext_erro_out;
   logic [PW-1:0] comp;

   no_addr_t ant_mem [1 << AW];
   beat_t    exp_q [$];
   no_addr_t rd_q [$];
   ev_t      ev_q [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int exp_lat = 0;
   int err_delta = 0;
   int exp_err_cyc = 0;
   int exp_comp = 0;
   int last_hs_cyc = 0;
   int hs_cnt = 0;
   int ready_mode = 0;
   bit first_pend = 1'b0;
   bit run_ok;

   logic     prev_valid = 1'b0;
   logic     prev_ready = 1'b0;
   no_addr_t prev_data = '0;
   beat_t    mb;

   caminho_extrator #(
      .ADDR_WIDTH   (AW),
      .MAX_PATH_LEN (MAXP)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .ext_start_in       (ext_start_in),
      .ext_fonte_in       (ext_fonte_in),
      .ext_destino_in     (ext_destino_in),
      .ext_ant_rd_out     (ext_ant_rd_out),
      .ext_ant_addr_out   (ext_ant_addr_out),
      .ext_ant_data_in    (ext_ant_data_in),
      .ext_path_valid_out (ext_path_valid_out),
      .ext_path_data_out  (ext_path_data_out),
      .ext_path_last_out  (ext_path_last_out),
      .ext_path_ready_in  (ext_path_ready_in),
      .ext_busy_out       (ext_busy_out),
      .ext_done_out       (ext_done_out),
      .ext_erro_out       (ext_erro_out)
`ifdef CAMINHO_COMPRIMENTO_EN
      ,
      .ext_comprimento_out (comp)
`endif
   );

`ifndef CAMINHO_COMPRIMENTO_EN
   assign comp = '0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Predecessor memory: data valid one cycle after the strobe, garbage otherwise.
   always @(posedge clk) ext_ant_data_in <= ext_ant_rd_out ? ant_mem[ext_ant_addr_out] : no_addr_t'($urandom);

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       ext_path_ready_in = 1'b1;
         1:       ext_path_ready_in = ~ext_path_ready_in;
         default: ext_path_ready_in = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("hold_valid", 32'(ext_path_valid_out), 1);
            check("hold_data", 32'(ext_path_data_out), 32'(prev_data));
         end
         if (ext_path_valid_out && first_pend) begin
            check("first_beat_latency", cyc - t0 + 1, exp_lat);
            first_pend = 1'b0;
         end
         if (ext_path_valid_out && ext_path_ready_in) begin
            if (exp_q.size() == 0) begin
               check("beat_unexpected", 32'(ext_path_valid_out), 0);
            end else begin
               mb = exp_q.pop_front();
               check("beat_data", 32'(ext_path_data_out), 32'(mb.data));
               check("beat_last", 32'(ext_path_last_out), 32'(mb.last));
            end
            hs_cnt++;
            if (ext_path_last_out) last_hs_cyc = cyc;
         end
         if (ext_ant_rd_out) begin
            if (rd_q.size() == 0) check("rd_unexpected", 32'(ext_ant_rd_out), 0);
            else check("rd_addr", 32'(ext_ant_addr_out), 32'(rd_q.pop_front()));
         end
         if (ext_done_out) begin
            if (ev_q.size() == 0 || ev_q[0] != EV_DONE) begin
               check("done_unexpected", 32'(ext_done_out), 0);
            end else begin
               void'(ev_q.pop_front());
               check("done_time", cyc, last_hs_cyc + 1);
               check("beats_left_at_done", exp_q.size(), 0);
            end
         end
         if (ext_erro_out) begin
            if (ev_q.size() == 0 || ev_q[0] != EV_ERRO) begin
               check("erro_unexpected", 32'(ext_erro_out), 0);
            end else begin
               void'(ev_q.pop_front());
               check("erro_time", cyc, exp_err_cyc);
               check("erro_valid", 32'(ext_path_valid_out), 0);
            end
         end
         prev_valid = ext_path_valid_out;
         prev_ready = ext_path_ready_in;
         prev_data  = ext_path_data_out;
      end
   end

   // Reference model: follow predecessors from destino until fonte, a sentinel, or a full stack.
   task automatic model(input no_addr_t f, input no_addr_t d, output bit ok);
      no_addr_t path [$];
      no_addr_t n;
      no_addr_t p;
      beat_t    nb;
      int       nreads;
      ok     = 1'b0;
      nreads = 0;
      n      = d;
      path.push_front(d);
      while (1) begin
         if (n == f) begin
            ok = 1'b1;
            break;
         end
         rd_q.push_back(n);
         nreads++;
         p = ant_mem[n];
         if (p == n || path.size() == MAXP) break;
         path.push_front(p);
         n = p;
      end
      if (ok) begin
         foreach (path[i]) begin
            nb.data = path[i];
            nb.last = (i == path.size() - 1);
            exp_q.push_back(nb);
         end
         ev_q.push_back(EV_DONE);
         exp_lat  = 2 + 2 * (path.size() - 1);
         exp_comp = path.size();
      end else begin
         ev_q.push_back(EV_ERRO);
         err_delta = 1 + 2 * nreads;
         exp_comp  = 0;
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < (1 << AW); i++) ant_mem[i] = no_addr_t'(i);
   endtask

   task automatic set_chain_12();
      clear_mem();
      ant_mem[12] = 9;
      ant_mem[9]  = 5;
      ant_mem[5]  = 2;
   endtask

   task automatic start_run(input no_addr_t f, input no_addr_t d, input int mode, input bit spurious);
      ready_mode = mode;
      hs_cnt     = 0;
      model(f, d, run_ok);
      @(posedge clk);
      #1;
      ext_start_in   = 1'b1;
      ext_fonte_in   = f;
      ext_destino_in = d;
      @(posedge clk);
      #1;
      t0          = cyc;
      exp_err_cyc = t0 + err_delta;
      first_pend  = run_ok;
      check("busy_after_start", 32'(ext_busy_out), 1);
      if (spurious) begin
         ext_fonte_in   = no_addr_t'($urandom);
         ext_destino_in = ext_fonte_in;
         @(posedge clk);
         #1;
      end
      ext_start_in   = 1'b0;
      ext_fonte_in   = no_addr_t'($urandom);
      ext_destino_in = no_addr_t'($urandom);
   endtask

   task automatic finish_run();
      for (int k = 0; k < 400 && ev_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      check("run_timeout", ev_q.size(), 0);
      exp_q.delete();
      ev_q.delete();
      @(posedge clk);
      #1;
      check("busy_idle", 32'(ext_busy_out), 0);
      check("valid_idle", 32'(ext_path_valid_out), 0);
      check("reads_left", rd_q.size(), 0);
      rd_q.delete();
`ifdef CAMINHO_COMPRIMENTO_EN
      check("comprimento", 32'(comp), exp_comp);
`endif
   endtask

   task automatic run_path(input no_addr_t f, input no_addr_t d, input int mode, input bit spurious);
      start_run(f, d, mode, spurious);
      finish_run();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(ext_path_valid_out), 0);
      check({tag, "_data"}, 32'(ext_path_data_out), 0);
      check({tag, "_last"}, 32'(ext_path_last_out), 0);
      check({tag, "_busy"}, 32'(ext_busy_out), 0);
      check({tag, "_done"}, 32'(ext_done_out), 0);
      check({tag, "_erro"}, 32'(ext_erro_out), 0);
      check({tag, "_rd"}, 32'(ext_ant_rd_out), 0);
      check({tag, "_addr"}, 32'(ext_ant_addr_out), 0);
      check({tag, "_comprimento"}, 32'(comp), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int nodes [6];
      int n;
      int base;
      int stride;
      clear_mem();
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // Single node: no reads, one beat with last.
      run_path(7, 7, 0, 0);

      // Four-node chain, ready high: one beat per cycle, first beat at cycle 8.
      set_chain_12();
      run_path(2, 12, 0, 0);

      // Same chain under alternating backpressure.
      run_path(2, 12, 1, 0);

      // Unreached destination, then a normal run.
      clear_mem();
      ant_mem[12] = 12;
      run_path(2, 12, 0, 0);
      set_chain_12();
      run_path(2, 12, 0, 0);

      // Five-node chain overflows a four-deep stack; the next run must see an empty stack.
      clear_mem();
      ant_mem[20] = 21;
      ant_mem[21] = 22;
      ant_mem[22] = 23;
      ant_mem[23] = 24;
      run_path(24, 20, 0, 0);
      set_chain_12();
      run_path(2, 12, 2, 0);

      // Reset during the stream, after two accepted beats.
      start_run(2, 12, 0, 0);
      for (int k = 0; k < 100 && hs_cnt < 2; k++) begin
         @(posedge clk);
         #1;
      end
      check("beats_before_reset", hs_cnt, 2);
      rst = 1'b1;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      rd_q.delete();
      ev_q.delete();
      first_pend = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("busy_after_midreset", 32'(ext_busy_out), 0);
      run_path(2, 12, 0, 0);

      // Randomised chains, broken chains and overflows, with random ready and ignored restarts.
      for (int r = 0; r < 40; r++) begin
         clear_mem();
         n      = $urandom_range(1, 6);
         base   = $urandom_range(0, 1000);
         stride = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) nodes[k] = base + k * stride;
         for (int k = 0; k < n - 1; k++) ant_mem[nodes[k]] = no_addr_t'(nodes[k + 1]);
         if (n > 1 && $urandom_range(0, 4) == 0) begin
            base = $urandom_range(0, n - 2);
            ant_mem[nodes[base]] = no_addr_t'(nodes[base]);
         end
         run_path(no_addr_t'(nodes[n - 1]), no_addr_t'(nodes[0]),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/caminho_extrator.md
Name: caminho_extrator

Overview:
- Sits directly downstream of the path-search core.
- Once the search finishes, it walks the predecessor (antecessor) memory backwards from destino to fonte and pushes each node onto an internal LIFO.
- It then streams the path out in forward order (fonte first, destino last) over a valid/ready interface.
- The stream feeds the route consumer (UART/host readback).

Parameters:
- ADDR_WIDTH, 10, node address width; matches the search core.
- MAX_PATH_LEN, 64, LIFO depth = maximum number of nodes in a path, destino and fonte included.
- PTR_WIDTH, $clog2(MAX_PATH_LEN+1), LIFO occupancy counter width; derived, never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ext_start_in  in  1  single-cycle pulse; search core has completed
- ext_fonte_in  in  ADDR_WIDTH  source node; sampled with ext_start_in
- ext_destino_in  in  ADDR_WIDTH  destination node; sampled with ext_start_in
- ext_ant_rd_out  out  1  predecessor memory read strobe
- ext_ant_addr_out  out  ADDR_WIDTH  predecessor memory read address
- ext_ant_data_in  in  ADDR_WIDTH  predecessor of the addressed node; valid exactly 1 cycle after ext_ant_rd_out
- ext_path_valid_out  out  1  path node valid
- ext_path_data_out  out  ADDR_WIDTH  path node
- ext_path_last_out  out  1  qualifies the final node (destino)
- ext_path_ready_in  in  1  consumer ready
- ext_busy_out  out  1  high in every state except IDLE
- ext_done_out  out  1  1-cycle pulse after the last beat is accepted
- ext_erro_out  out  1  1-cycle pulse on abort (no path or overflow)

Behaviour:
- Reset values:
  - All outputs 0; LIFO empty; FSM in IDLE.
  - Reset asserted mid-operation aborts immediately: no done, no erro, stream drops.
- States: IDLE, PUSH_DST, LER, ESPERA, STREAM, FIM, ERRO.
- IDLE:
  - On ext_start_in, latch fonte/destino and set cur=destino; go to PUSH_DST.
  - ext_start_in while busy is ignored.
- PUSH_DST:
  - Push destino, one cycle.
  - If destino==fonte, go to STREAM (single-node path); else go to LER.
- LER:
  - Assert ext_ant_rd_out=1 and ext_ant_addr_out=cur for one cycle; go to ESPERA.
- ESPERA: sample p=ext_ant_data_in, then apply the first matching rule:
  - p==cur (self-predecessor = unreached sentinel): go to ERRO.
  - LIFO full (count==MAX_PATH_LEN): go to ERRO. The overflow check precedes the push.
  - Otherwise push p and set cur=p; go to STREAM if p==fonte, else go to LER.
  - Net cost: 2 cycles per hop.
- STREAM:
  - ext_path_data_out = LIFO top; ext_path_valid_out=1.
  - ext_path_last_out=1 when count==1.
  - Pop only on valid&&ready. Data and valid hold stable while ready=0 (AXI-stream rules).
  - After the last pop, go to FIM.
- FIM: ext_done_out=1 for one cycle; go to IDLE.
- ERRO: ext_erro_out=1 for one cycle; flush LIFO (count=0); go to IDLE.
- Latency:
  - Path of N nodes: first beat valid 2 + 2*(N-1) cycles after the start pulse.
  - With ready held high: N beats, one per cycle.
- No combinational path from ext_path_ready_in to any output.

Optional Feature:
- Macro CAMINHO_COMPRIMENTO_EN.
- Enabled:
  - Extra output ext_comprimento_out, PTR_WIDTH bits = number of nodes in the path.
  - Registered when leaving ESPERA/PUSH_DST for STREAM; held until the next ext_start_in.
  - Reset value 0; cleared to 0 on ERRO.
- Disabled: the port and its register do not exist; all other behaviour is identical.

Decomposition:
- Package caminho_pkg:
  - State enum caminho_estado_t.
  - Default ADDR_WIDTH/MAX_PATH_LEN constants.
  - Node address typedef no_addr_t.
- Sub-module caminho_pilha:
  - Parameterised LIFO (DEPTH, WIDTH).
  - Ports: push, pop, flush, data_in, top_out, count_out, full_out, empty_out.
  - Simultaneous push&pop never occurs (guaranteed by the FSM); asserted in simulation.

Test Plan:
- Single node: fonte=7, destino=7, ready=1 -> no ant reads; one beat data=7 with last=1; done pulse 1 cycle later.
- Chain: ant[12]=9, ant[9]=5, ant[5]=2, fonte=2, destino=12, ready=1 -> reads at 12, 9, 5; beats 2, 5, 9, 12, last only on 12; first beat at cycle 8 after start.
- Backpressure: same chain, ready toggling 1/0 every cycle -> data held while ready=0; order 2, 5, 9, 12 intact; exactly 4 handshakes.
- No path: ant[12]=12, fonte=2, destino=12 -> erro pulse, no valid beats, busy low afterward, next start works normally.
- Overflow: MAX_PATH_LEN=4, chain of 5 nodes -> erro pulse after the 4th push; LIFO flushed; no beats.
- Reset mid-stream: assert rst after 2 beats of the chain test -> all outputs 0 asynchronously; no done; restart yields the full 2, 5, 9, 12.
